ln_ctrl: RTL
============

LN_CTRL -- requirements
Module: ln_ctrl

Parameters
REQ-001 SHALL have parameter CLR_CYC, default 2, giving the number of cycles the ln datapath is held cleared after each start.
REQ-002 SHALL have parameter LN_TIMEOUT, default 64, giving the maximum number of cycles to wait in LN for a result before flagging an error.

Interface
REQ-003 clock_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  begins one pass; sampled only in IDLE.
REQ-006 len_i  in  8  vector length, captured on an accepted start.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 done_o  out  1  one-cycle end-of-pass pulse.
REQ-009 err_o  out  1  sticky error flag, cleared by the next accepted start.
REQ-010 sum_data_i  in  32  Q4.28 exponent sum from the adder.
REQ-011 sum_valid_i  in  1  qualifies sum_data_i.
REQ-012 ln_clr_n_o  out  1  active-low clear to the ln datapath's reset input.
REQ-013 ln_data_o  out  32  Q4.28 operand to the ln datapath.
REQ-014 ln_data_valid_o  out  1  operand valid to the ln datapath.
REQ-015 ln_result_i  in  32  ln datapath result.
REQ-016 ln_result_valid_i  in  1  ln datapath result valid (sticky while not cleared).
REQ-017 sub_ln_o  out  32  latched ln result for the subtractor.
REQ-018 sub_en_o  out  1  element offer to the subtractor.
REQ-019 sub_idx_o  out  8  index of the offered element.
REQ-020 sub_ready_i  in  1  subtractor accept; a transfer occurs when sub_en_o && sub_ready_i.

Function
REQ-021 SHALL implement a Moore FSM with states IDLE, CLR, WAIT_SUM, LN, SUB, DONE, and SHALL drive all outputs from registers.
REQ-022 IDLE: start_i=1 with len_i!=0 SHALL capture len_i, clear err_o and go to CLR.
REQ-023 IDLE: start_i=1 with len_i==0 SHALL set err_o, pulse done_o on the next cycle and remain in IDLE.
REQ-024 ln_clr_n_o SHALL be 0 in IDLE and CLR, and 1 in all other states.
REQ-025 CLR SHALL last exactly CLR_CYC cycles and then go to WAIT_SUM.
REQ-026 WAIT_SUM: on sum_valid_i=1 with sum_data_i!=0, SHALL latch sum_data_i into ln_data_o and go to LN.
REQ-027 WAIT_SUM: on sum_valid_i=1 with sum_data_i==0, SHALL set err_o and go to DONE, because ln(0) is undefined and the datapath normaliser would never terminate.
REQ-028 WAIT_SUM: SHALL have no timeout and SHALL ignore sum_valid_i in every other state.
REQ-029 LN: ln_data_valid_o SHALL be held at 1 and a wait counter SHALL start at 0 on entry.
REQ-030 LN: on ln_result_valid_i=1, SHALL latch ln_result_i into sub_ln_o and go to SUB.
REQ-031 LN: if the wait counter reaches LN_TIMEOUT with no result, SHALL set err_o and go to DONE.
REQ-032 LN: a result arriving in the same cycle the counter reaches LN_TIMEOUT SHALL take priority over the timeout.
REQ-033 SUB: sub_en_o SHALL be 1 and sub_idx_o SHALL start at 0.
REQ-034 SUB: each transfer SHALL increment sub_idx_o.
REQ-035 SUB: a transfer at sub_idx_o==len-1 SHALL go to DONE.
REQ-036 SUB: while sub_ready_i=0, sub_idx_o SHALL hold.
REQ-037 sub_idx_o SHALL never exceed len-1 and SHALL NOT wrap.
REQ-038 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-039 sub_ln_o SHALL hold its value until the next latch in LN.
REQ-040 start_i SHALL be ignored in every state other than IDLE.
REQ-041 Latency: with start accepted at cycle 0, WAIT_SUM SHALL be entered at cycle CLR_CYC+1.
REQ-042 Latency: sum_valid_i at cycle t SHALL give ln_data_valid_o=1 at cycle t+1.
REQ-043 Latency: ln_result_valid_i at cycle u SHALL give sub_en_o=1 at cycle u+1.

Reset
REQ-044 On reset_i=1, SHALL enter IDLE asynchronously.
REQ-045 Reset values: busy_o=0, done_o=0, err_o=0, ln_clr_n_o=0, ln_data_o=0, ln_data_valid_o=0, sub_ln_o=0, sub_en_o=0, sub_idx_o=0, and all counters 0.
REQ-046 Reset asserted mid-pass SHALL abort the pass with no done_o pulse.

Verification
REQ-047 Nominal pass: len=4, CLR_CYC=2, sum=0x10000000, result after 3 cycles, sub_ready_i=1 -> ln_clr_n_o low cycles 1-2, ln_data_o=0x10000000, sub_idx_o 0..3 on consecutive cycles, single done_o, err_o=0.
REQ-048 Zero length: start with len=0 -> err_o=1, one done_o pulse, busy_o stays 0; the next start with len=2 clears err_o.
REQ-049 Zero sum: sum_data_i=0 -> err_o=1, ln_data_valid_o never asserted, done_o pulse.
REQ-050 Timeout: ln_result_valid_i held low -> err_o set exactly LN_TIMEOUT cycles after entering LN, then done_o.
REQ-051 Backpressure: sub_ready_i toggling 1,0,0,1,... with len=3 -> sub_idx_o holds while not ready, exactly 3 transfers, and start_i pulsed during SUB is ignored.
REQ-052 Mid-pass reset: reset_i pulsed while in LN -> all outputs at reset values immediately, no done_o pulse, and a following pass completes normally.

Source files
------------

// File: rtl/ln_ctrl.sv
// ln_ctrl: sequences one log-normalisation pass. It clears the ln datapath,
// waits for the exponent sum, feeds it to the ln datapath and waits for the
// result. It then offers len elements to the subtractor and ends with a
// one-cycle done pulse. Every output comes straight from a register.
module ln_ctrl #(
  parameter int CLR_CYC    = 2,
  parameter int LN_TIMEOUT = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [31:0] sum_data_i,
  input  logic        sum_valid_i,
  output logic        ln_clr_n_o,
  output logic [31:0] ln_data_o,
  output logic        ln_data_valid_o,
  input  logic [31:0] ln_result_i,
  input  logic        ln_result_valid_i,
  output logic [31:0] sub_ln_o,
  output logic        sub_en_o,
  output logic [7:0]  sub_idx_o,
  input  logic        sub_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT_SUM,
    S_LN,
    S_SUB,
    S_DONE
  } state_e;

  localparam int CLR_W   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int LNCNT_W = $clog2(LN_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CLR_W-1:0]   clrCnt_q, clrCnt_d;
  logic [LNCNT_W-1:0] lnCnt_q, lnCnt_d;
  logic [7:0]         len_q, len_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               clrN_q, clrN_d;
  logic [31:0]        lnData_q, lnData_d;
  logic               lnValid_q, lnValid_d;
  logic [31:0]        subLn_q, subLn_d;
  logic               subEn_q, subEn_d;
  logic [7:0]         subIdx_q, subIdx_d;
  logic               zeroLenDone;
  logic [LNCNT_W-1:0] lnCntInc;

  // The LN wait counter "reaches" LN_TIMEOUT on the edge where it would
  // become LN_TIMEOUT. err_o therefore rises exactly LN_TIMEOUT cycles after
  // LN is entered. A result seen on that same edge still wins.
  assign lnCntInc = lnCnt_q + LNCNT_W'(1);

  // Next-state logic. The output registers are loaded from a decode of the
  // next state, so the outputs always match the state they belong to.
  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    lnCnt_d     = lnCnt_q;
    len_d       = len_q;
    err_d       = err_q;
    lnData_d    = lnData_q;
    subLn_d     = subLn_q;
    subIdx_d    = subIdx_q;
    zeroLenDone = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != 8'd0) begin
            len_d    = len_i;
            err_d    = 1'b0;
            clrCnt_d = '0;
            state_d  = S_CLR;
          end else begin
            err_d       = 1'b1;
            zeroLenDone = 1'b1;
          end
        end
      end
      S_CLR: begin
        if (clrCnt_q == CLR_W'(CLR_CYC - 1)) begin
          state_d = S_WAIT_SUM;
        end else begin
          clrCnt_d = clrCnt_q + CLR_W'(1);
        end
      end
      S_WAIT_SUM: begin
        if (sum_valid_i) begin
          if (sum_data_i != 32'd0) begin
            lnData_d = sum_data_i;
            lnCnt_d  = '0;
            state_d  = S_LN;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LN: begin
        if (ln_result_valid_i) begin
          subLn_d  = ln_result_i;
          subIdx_d = 8'd0;
          state_d  = S_SUB;
        end else if (lnCntInc == LNCNT_W'(LN_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          lnCnt_d = lnCntInc;
        end
      end
      S_SUB: begin
        if (subEn_q && sub_ready_i) begin
          if (subIdx_q == len_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            subIdx_d = subIdx_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    clrN_d    = !((state_d == S_IDLE) || (state_d == S_CLR));
    lnValid_d = (state_d == S_LN);
    subEn_d   = (state_d == S_SUB);
    done_d    = (state_d == S_DONE) || zeroLenDone;
  end

  // State and output registers; reset aborts any pass without a done pulse.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      clrCnt_q  <= '0;
      lnCnt_q   <= '0;
      len_q     <= 8'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      clrN_q    <= 1'b0;
      lnData_q  <= 32'd0;
      lnValid_q <= 1'b0;
      subLn_q   <= 32'd0;
      subEn_q   <= 1'b0;
      subIdx_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      clrCnt_q  <= clrCnt_d;
      lnCnt_q   <= lnCnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      clrN_q    <= clrN_d;
      lnData_q  <= lnData_d;
      lnValid_q <= lnValid_d;
      subLn_q   <= subLn_d;
      subEn_q   <= subEn_d;
      subIdx_q  <= subIdx_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign ln_clr_n_o      = clrN_q;
  assign ln_data_o       = lnData_q;
  assign ln_data_valid_o = lnValid_q;
  assign sub_ln_o        = subLn_q;
  assign sub_en_o        = subEn_q;
  assign sub_idx_o       = subIdx_q;

endmodule
